// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: one VRAM-style access bus.
//   sel   - request / access strobe, held until ack or err
//   wr    - 1 = write, 0 = read
//   mask  - byte/nibble mask
//   addr  - word address
//   wdata - write data
//   rdata - read data, valid with ack
//   ack   - access complete, 1-cycle pulse
//   err   - access aborted, 1-cycle pulse (not driven on the VRAM side)
// master: the side that issues requests. slave: the side that serves them.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  sel;
  logic                  wr;
  logic [3:0]            mask;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;
  logic                  err;

  modport master (output sel, wr, mask, addr, wdata, input rdata, ack, err);
  modport slave  (input sel, wr, mask, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single VRAM port between port 0 (rasterizer write
// stream) and port 1 (host access). Round-robin, one access in flight, all
// VRAM-side and requester-side outputs registered, per-access ack watchdog.
// Ports:
//   clk     - clock
//   reset_i - asynchronous reset, active high
//   m0      - port 0 requester bus (slave side)
//   m1      - port 1 requester bus (slave side)
//   vram    - VRAM controller bus (master side); vram.err is not used
module vram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic           clk,
  input  logic           reset_i,
  vram_arbiter_if.slave  m0,
  vram_arbiter_if.slave  m1,
  vram_arbiter_if.master vram
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e                state_q;
  logic                  ptr_q;    // port that wins when both request
  logic                  owner_q;  // port that owns the access in flight
  logic [CntW-1:0]       cnt_q;
  logic                  vsel_q;
  logic                  vwr_q;
  logic [3:0]            vmask_q;
  logic [ADDR_WIDTH-1:0] vaddr_q;
  logic [DATA_WIDTH-1:0] vdata_q;
  logic                  m0_ack_q, m0_err_q, m1_ack_q, m1_err_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;
  logic                  grant;

  // Port 1 wins if it is the only requester, or both request and it holds priority.
  assign grant = m1.sel & (~m0.sel | ptr_q);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      vsel_q     <= 1'b0;
      vwr_q      <= 1'b0;
      vmask_q    <= '0;
      vaddr_q    <= '0;
      vdata_q    <= '0;
      m0_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      // ack/err are single-cycle pulses
      m0_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m1_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (m0.sel || m1.sel) begin
            owner_q <= grant;
            ptr_q   <= ~grant;
            cnt_q   <= '0;
            vsel_q  <= 1'b1;
            vwr_q   <= grant ? m1.wr    : m0.wr;
            vmask_q <= grant ? m1.mask  : m0.mask;
            vaddr_q <= grant ? m1.addr  : m0.addr;
            vdata_q <= grant ? m1.wdata : m0.wdata;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          // ack takes precedence over a watchdog expiry in the same cycle
          if (vram.ack) begin
            vsel_q <= 1'b0;
            vwr_q  <= 1'b0;
            if (owner_q) begin
              m1_ack_q <= 1'b1;
              if (!vwr_q) m1_rdata_q <= vram.rdata;
            end else begin
              m0_ack_q <= 1'b1;
              if (!vwr_q) m0_rdata_q <= vram.rdata;
            end
            state_q <= StAck;
          end else if (cnt_q == CntLast) begin
            vsel_q <= 1'b0;
            vwr_q  <= 1'b0;
            if (owner_q) m1_err_q <= 1'b1;
            else         m0_err_q <= 1'b1;
            state_q <= StAck;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StAck:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign vram.sel   = vsel_q;
  assign vram.wr    = vwr_q;
  assign vram.mask  = vmask_q;
  assign vram.addr  = vaddr_q;
  assign vram.wdata = vdata_q;

  assign m0.ack   = m0_ack_q;
  assign m0.err   = m0_err_q;
  assign m0.rdata = m0_rdata_q;
  assign m1.ack   = m1_ack_q;
  assign m1.err   = m1_err_q;
  assign m1.rdata = m1_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic clk = 1'b0;
  logic reset_i;
  int   n_cmp  = 0;
  int   n_fail = 0;

  vram_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) m0_if ();
  vram_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) m1_if ();
  vram_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) v_if ();

  vram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(8)) dut (
    .clk    (clk),
    .reset_i(reset_i),
    .m0     (m0_if),
    .m1     (m1_if),
    .vram   (v_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the VRAM strobe; lands in the first cycle it is high.
  task automatic wait_sel(input string tag);
    int n = 0;
    tick();
    while (!v_if.sel && n < 10) begin
      tick();
      n++;
    end
    check(tag, 32'(v_if.sel), 32'd1);
  endtask

  initial begin
    int cnt;
    logic win;

    reset_i     = 1'b1;
    m0_if.sel   = 0; m0_if.wr = 0; m0_if.mask = 0; m0_if.addr = 0; m0_if.wdata = 0;
    m1_if.sel   = 0; m1_if.wr = 0; m1_if.mask = 0; m1_if.addr = 0; m1_if.wdata = 0;
    v_if.ack    = 0; v_if.rdata = 0; v_if.err = 0;
    tick();
    tick();
    check("rst_vsel", 32'(v_if.sel), 0);
    check("rst_vwr", 32'(v_if.wr), 0);
    check("rst_vaddr", 32'(v_if.addr), 0);
    check("rst_vdata", 32'(v_if.wdata), 0);
    check("rst_m0ack", 32'(m0_if.ack), 0);
    check("rst_m1err", 32'(m1_if.err), 0);
    check("rst_m1data", 32'(m1_if.rdata), 0);
    reset_i = 1'b0;

    // 1: m0 write, VRAM acks one cycle after the strobe
    m0_if.sel = 1; m0_if.wr = 1; m0_if.mask = 4'hF; m0_if.addr = 16'h0010;
    m0_if.wdata = 16'hF123;
    tick();
    check("t1_vsel", 32'(v_if.sel), 1);
    check("t1_vaddr", 32'(v_if.addr), 32'h0010);
    check("t1_vdata", 32'(v_if.wdata), 32'hF123);
    check("t1_vwr", 32'(v_if.wr), 1);
    check("t1_vmask", 32'(v_if.mask), 32'hF);
    check("t1_m0ack_early", 32'(m0_if.ack), 0);
    tick();
    v_if.ack = 1;
    tick();
    v_if.ack = 0;
    m0_if.sel = 0;
    check("t1_m0ack", 32'(m0_if.ack), 1);
    check("t1_m1ack", 32'(m1_if.ack), 0);
    check("t1_vsel_drop", 32'(v_if.sel), 0);
    tick();
    check("t1_m0ack_pulse", 32'(m0_if.ack), 0);

    // 3: m1 read
    m1_if.sel = 1; m1_if.wr = 0; m1_if.mask = 4'h3; m1_if.addr = 16'h3FFF;
    wait_sel("t3_grant");
    check("t3_vaddr", 32'(v_if.addr), 32'h3FFF);
    check("t3_vwr", 32'(v_if.wr), 0);
    v_if.ack = 1; v_if.rdata = 16'hABCD;
    tick();
    v_if.ack = 0; v_if.rdata = 16'h0;
    m1_if.sel = 0;
    check("t3_m1ack", 32'(m1_if.ack), 1);
    check("t3_m1data", 32'(m1_if.rdata), 32'hABCD);
    check("t3_m0ack", 32'(m0_if.ack), 0);
    check("t3_vwr_after", 32'(v_if.wr), 0);

    // 2: both requesting from reset, grants must alternate starting at port 0
    reset_i = 1'b1;
    tick();
    check("t2_rst_m1data", 32'(m1_if.rdata), 0);
    reset_i = 1'b0;
    m0_if.sel = 1; m0_if.wr = 1; m0_if.mask = 4'hF; m0_if.addr = 16'h0100; m0_if.wdata = 16'h1111;
    m1_if.sel = 1; m1_if.wr = 0; m1_if.mask = 4'hF; m1_if.addr = 16'h0200;
    for (int i = 0; i < 8; i++) begin
      win = i[0];
      wait_sel($sformatf("t2_grant%0d", i));
      check($sformatf("t2_addr%0d", i), 32'(v_if.addr), win ? 32'h0200 : 32'h0100);
      v_if.ack = 1; v_if.rdata = 16'(16'h5000 + i);
      tick();
      v_if.ack = 0;
      check($sformatf("t2_m0ack%0d", i), 32'(m0_if.ack), win ? 0 : 1);
      check($sformatf("t2_m1ack%0d", i), 32'(m1_if.ack), win ? 1 : 0);
      if (win) check($sformatf("t2_m1data%0d", i), 32'(m1_if.rdata), 32'h5000 + 32'(i));
    end
    check("t2_m0data_hold", 32'(m0_if.rdata), 0);
    check("t2_m1data_hold", 32'(m1_if.rdata), 32'h5007);
    m1_if.sel = 0;

    // 4: m0 write with no VRAM ack, watchdog of 8 cycles
    wait_sel("t4_grant");
    cnt = 0;
    while (v_if.sel && cnt < 20) begin
      cnt++;
      tick();
    end
    check("t4_sel_cycles", 32'(cnt), 8);
    check("t4_m0err", 32'(m0_if.err), 1);
    check("t4_m0ack", 32'(m0_if.ack), 0);
    m0_if.sel = 0;
    tick();
    check("t4_m0err_pulse", 32'(m0_if.err), 0);

    // 5: ack arrives on the watchdog's final cycle
    m0_if.sel = 1;
    wait_sel("t5_grant");
    for (int i = 0; i < 7; i++) tick();
    check("t5_vsel_last", 32'(v_if.sel), 1);
    v_if.ack = 1;
    tick();
    v_if.ack = 0;
    m0_if.sel = 0;
    check("t5_m0ack", 32'(m0_if.ack), 1);
    check("t5_m0err", 32'(m0_if.err), 0);

    // 6: reset mid-access, stale ack afterwards, priority back to port 0
    m0_if.sel = 1;
    m1_if.sel = 1;
    wait_sel("t6_grant");
    check("t6_owner_m1", 32'(v_if.addr), 32'h0200);
    tick();
    reset_i = 1'b1;
    #1;
    check("t6_vsel_async", 32'(v_if.sel), 0);
    check("t6_m1ack_rst", 32'(m1_if.ack), 0);
    check("t6_m1err_rst", 32'(m1_if.err), 0);
    m0_if.sel = 0;
    m1_if.sel = 0;
    tick();
    reset_i = 1'b0;
    v_if.ack = 1;
    tick();
    v_if.ack = 0;
    check("t6_stale_m0ack", 32'(m0_if.ack), 0);
    check("t6_stale_m1ack", 32'(m1_if.ack), 0);
    check("t6_stale_vsel", 32'(v_if.sel), 0);
    tick();
    check("t6_stale_m1ack2", 32'(m1_if.ack), 0);
    m0_if.sel = 1;
    m1_if.sel = 1;
    wait_sel("t6_regrant");
    check("t6_regrant_addr", 32'(v_if.addr), 32'h0100);
    check("t6_regrant_wr", 32'(v_if.wr), 1);
    m0_if.sel = 0;
    m1_if.sel = 0;
    v_if.ack = 1;
    tick();
    v_if.ack = 0;
    check("t6_final_m0ack", 32'(m0_if.ack), 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
